pll_lock_sequencer: RTL and testbench

PLL_LOCK_SEQUENCER -- requirements
Module: pll_lock_sequencer

---
 rtl/pll_lock_sequencer.sv | 123 ++++++++++++
 tb/tb_pll_lock_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// PLL bring-up sequencer: holds the PLL in reset, waits for a synchronized lock, and releases the system reset once lock is stable.
// Optional retry limit with a terminal FAIL state is enabled by defining PLL_RETRY_LIMIT_EN.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned STABLE_CYCLES = 256,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic       clkin,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       restart,
    output logic       pll_reset,
    output logic       sys_reset,
    output logic       ready,
    output logic [3:0] retry_count,
    output logic       fail,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_HOLD      = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    localparam logic [15:0] RST_LAST     = 16'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(STABLE_CYCLES - 1);

    if (RST_CYCLES < 1 || RST_CYCLES > 65535 || LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535 ||
        STABLE_CYCLES < 1 || STABLE_CYCLES > 65535 || MAX_RETRIES < 1 || MAX_RETRIES > 15) begin : g_bad_param
        $error("pll_lock_sequencer: parameter out of range");
    end

    state_t      cur_state;
    state_t      nxt_state;
    logic [15:0] cnt;
    logic [3:0]  retry_nxt;
    logic        lock_p0;
    logic        lock_p1;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    always_comb begin
        nxt_state = cur_state;
        retry_nxt = retry_count;
        if (restart) begin
            nxt_state = S_HOLD;
            retry_nxt = 4'd0;
        end else begin
            case (cur_state)
                S_HOLD: begin
                    if (cnt == RST_LAST) nxt_state = S_WAIT_LOCK;
                end
                S_WAIT_LOCK: begin
                    if (lock_p1) begin
                        nxt_state = S_STABLE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        retry_nxt = sat_inc(retry_count);
`ifdef PLL_RETRY_LIMIT_EN
                        nxt_state = (retry_count == 4'(MAX_RETRIES - 1)) ? S_FAIL : S_HOLD;
`else
                        nxt_state = S_HOLD;
`endif
                    end
                end
                S_STABLE: begin
                    if (!lock_p1) begin
                        nxt_state = S_WAIT_LOCK;
                    end else if (cnt == STABLE_LAST) begin
                        nxt_state = S_RUN;
                        retry_nxt = 4'd0;
                    end
                end
                S_RUN: begin
                    if (!lock_p1) nxt_state = S_HOLD;
                end
                S_FAIL:  nxt_state = S_FAIL;
                default: nxt_state = S_HOLD;
            endcase
        end
    end

    // Outputs are registered from the next state so they switch on the same edge as the state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_p0     <= 1'b0;
            lock_p1     <= 1'b0;
            cur_state   <= S_HOLD;
            cnt         <= 16'd0;
            retry_count <= 4'd0;
            pll_reset   <= 1'b1;
            sys_reset   <= 1'b1;
            ready       <= 1'b0;
        end else begin
            lock_p0     <= pll_locked;
            lock_p1     <= lock_p0;
            cur_state   <= nxt_state;
            cnt         <= (restart || nxt_state != cur_state) ? 16'd0 : cnt + 16'd1;
            retry_count <= retry_nxt;
            pll_reset   <= (nxt_state == S_HOLD) || (nxt_state == S_FAIL);
            sys_reset   <= (nxt_state != S_RUN);
            ready       <= (nxt_state == S_RUN);
        end
    end

`ifdef PLL_RETRY_LIMIT_EN
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) fail <= 1'b0;
        else       fail <= (nxt_state == S_FAIL);
    end
`else
    assign fail = 1'b0;
`endif

    assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2.
// Edge numbers in the comments count rising edges after reset release.
module tb_pll_lock_sequencer;

    logic       clkin = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       restart = 1'b0;
    logic       pll_reset;
    logic       sys_reset;
    logic       ready;
    logic [3:0] retry_count;
    logic       fail;
    logic [2:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    pll_lock_sequencer #(
        .RST_CYCLES(4), .LOCK_TIMEOUT(32), .STABLE_CYCLES(8), .MAX_RETRIES(2)
    ) dut (
        .clkin(clkin), .reset(reset), .pll_locked(pll_locked), .restart(restart),
        .pll_reset(pll_reset), .sys_reset(sys_reset), .ready(ready),
        .retry_count(retry_count), .fail(fail), .state(state)
    );

    always #5 clkin = ~clkin;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        chk("rst_state", int'(state), 0);
        chk("rst_pll_reset", int'(pll_reset), 1);
        chk("rst_sys_reset", int'(sys_reset), 1);
        chk("rst_ready", int'(ready), 0);
        chk("rst_retry", int'(retry_count), 0);
        chk("rst_fail", int'(fail), 0);
        reset = 1'b0;
    endtask

    initial begin
        // Lock present throughout: the synchronizer fills while still in HOLD.
        pll_locked = 1'b1;
        do_reset();
        tick(3);  chk("a_hold_e3", int'(state), 0); chk("a_pllrst_e3", int'(pll_reset), 1);
        tick(1);  chk("a_wait_e4", int'(state), 1); chk("a_pllrst_e4", int'(pll_reset), 0);
        chk("a_sysrst_e4", int'(sys_reset), 1);
        tick(1);  chk("a_stable_e5", int'(state), 2);
        tick(7);  chk("a_ready_e12", int'(ready), 0); chk("a_sysrst_e12", int'(sys_reset), 1);
        tick(1);  chk("a_ready_e13", int'(ready), 1); chk("a_sysrst_e13", int'(sys_reset), 0);
        chk("a_run_e13", int'(state), 3); chk("a_retry_e13", int'(retry_count), 0);

        // Lock loss in RUN reaches the outputs three edges later.
        pll_locked = 1'b0;
        tick(2);  chk("b_ready_2", int'(ready), 1); chk("b_sysrst_2", int'(sys_reset), 0);
        tick(1);  chk("b_sysrst_3", int'(sys_reset), 1); chk("b_ready_3", int'(ready), 0);
        chk("b_hold_3", int'(state), 0); chk("b_pllrst_3", int'(pll_reset), 1);

        // Three-cycle lock drop during STABLE.
        pll_locked = 1'b1;
        do_reset();
        tick(6);  chk("c_stable_e6", int'(state), 2);
        pll_locked = 1'b0;
        tick(3);  chk("c_wait_e9", int'(state), 1); chk("c_retry_e9", int'(retry_count), 0);
        pll_locked = 1'b1;
        tick(2);  chk("c_wait_e11", int'(state), 1);
        tick(1);  chk("c_stable_e12", int'(state), 2);
        tick(7);  chk("c_stable_e19", int'(state), 2);
        tick(1);  chk("c_run_e20", int'(state), 3); chk("c_retry_e20", int'(retry_count), 0);

        // Restart from RUN.
        tick(3);
        restart = 1'b1;
        tick(1);  chk("d_hold", int'(state), 0); chk("d_pllrst", int'(pll_reset), 1);
        chk("d_sysrst", int'(sys_reset), 1);
        restart = 1'b0;

        // One timeout, then lock rises after edge 40.
        pll_locked = 1'b0;
        do_reset();
        tick(4);  chk("e_wait_e4", int'(state), 1);
        tick(31); chk("e_wait_e35", int'(state), 1); chk("e_retry_e35", int'(retry_count), 0);
        tick(1);  chk("e_hold_e36", int'(state), 0); chk("e_retry_e36", int'(retry_count), 1);
        chk("e_pllrst_e36", int'(pll_reset), 1);
        tick(3);  chk("e_pllrst_e39", int'(pll_reset), 1);
        tick(1);  chk("e_pllrst_e40", int'(pll_reset), 0); chk("e_wait_e40", int'(state), 1);
        pll_locked = 1'b1;
        tick(2);  chk("e_wait_e42", int'(state), 1);
        tick(1);  chk("e_stable_e43", int'(state), 2); chk("e_retry_e43", int'(retry_count), 1);
        tick(7);  chk("e_stable_e50", int'(state), 2);
        tick(1);  chk("e_run_e51", int'(state), 3); chk("e_retry_e51", int'(retry_count), 0);
        chk("e_ready_e51", int'(ready), 1);

        // Restart coinciding with a timeout wins.
        pll_locked = 1'b0;
        do_reset();
        tick(35); chk("f_wait_e35", int'(state), 1);
        restart = 1'b1;
        tick(1);  chk("f_hold_e36", int'(state), 0); chk("f_retry_e36", int'(retry_count), 0);
        restart = 1'b0;
        tick(3);  chk("f_hold_e39", int'(state), 0);
        tick(1);  chk("f_wait_e40", int'(state), 1);

        // Lock never arrives.
        do_reset();
        tick(36); chk("g_retry_e36", int'(retry_count), 1); chk("g_hold_e36", int'(state), 0);
        tick(36);
`ifdef PLL_RETRY_LIMIT_EN
        chk("g_fail_state", int'(state), 4); chk("g_fail", int'(fail), 1);
        chk("g_fail_pllrst", int'(pll_reset), 1); chk("g_fail_retry", int'(retry_count), 2);
        chk("g_fail_sysrst", int'(sys_reset), 1); chk("g_fail_ready", int'(ready), 0);
        tick(10); chk("g_fail_stays", int'(state), 4);
        restart = 1'b1;
        tick(1);  chk("g_restart_state", int'(state), 0); chk("g_restart_retry", int'(retry_count), 0);
        chk("g_restart_fail", int'(fail), 0);
        restart = 1'b0;
`else
        chk("g_hold_e72", int'(state), 0); chk("g_retry_e72", int'(retry_count), 2);
        chk("g_fail_e72", int'(fail), 0);
        tick(467); chk("g_retry_e539", int'(retry_count), 14);
        tick(1);   chk("g_retry_e540", int'(retry_count), 15); chk("g_hold_e540", int'(state), 0);
        tick(100); chk("g_retry_sat", int'(retry_count), 15); chk("g_fail_none", int'(fail), 0);
`endif

        // Asynchronous reset applied while in RUN.
        pll_locked = 1'b1;
        do_reset();
        tick(13); chk("h_run", int'(state), 3);
        #2 reset = 1'b1;
        #1;
        chk("h_async_pllrst", int'(pll_reset), 1); chk("h_async_sysrst", int'(sys_reset), 1);
        chk("h_async_state", int'(state), 0); chk("h_async_ready", int'(ready), 0);
        tick(1);
        do_reset();
        tick(3);  chk("h_hold_e3", int'(state), 0);
        tick(1);  chk("h_wait_e4", int'(state), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
